keypad_decoder: RTL and testbench

Scans a 4x4 matrix keypad, debounces it, and converts the pressed key into a 4-bit hex code with a one-cycle valid strobe. The block sits on the input side of the display path. Its `key_val` output is the 4-bit value that the hex-to-seven-segment decoder consumes, so a key press becomes a displayed digit.

---
 rtl/keypad_decoder_if.sv | 25 ++
 rtl/keypad_decoder.sv | 148 ++++++++++++++
 tb/tb_keypad_decoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_decoder_if.sv
// Keypad-side and display-side signals of the keypad decoder.
// The master modport is the decoder; the slave modport is the keypad/consumer side.
interface keypad_decoder_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_val;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_val,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_val,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad scanner with full-scan debouncing.
// Emits the hex code of an accepted key with a one-cycle valid strobe.
module keypad_decoder #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic              clk,
    input logic              rst_n,
    keypad_decoder_if.master kp
);
    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
    // Snapshot index is col*4+row; nibble i holds that key's hex code.
    localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_e;
    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_class_e;
    typedef struct packed {
        res_class_e cls;
        logic [3:0] code;
    } scan_result_t;
    typedef enum logic {IDLE, PRESSED} key_state_e;

    logic [3:0]   sync1_q, sync2_q;
    col_state_e   col_state_q;
    logic [3:0]   col_q;
    logic [DW-1:0] dwell_q;
    logic [11:0]  snap_q;
    scan_result_t prev_q;
    logic [SW-1:0] stable_q;

    key_state_e   key_state_q;
    logic [3:0]   key_val_q;
    logic         key_valid_q;
    logic         key_held_q;

    logic         sample;
    logic         scan_done;
    logic         same_res;
    logic         accept;
    logic [15:0]  snap_full;
    logic [4:0]   low_cnt;
    logic [3:0]   low_idx;
    scan_result_t scan_res;
    col_state_e   col_state_d;

    assign sample      = (dwell_q == DWELL_LAST);
    assign scan_done   = sample && (col_state_q == COL3);
    assign col_state_d = col_state_e'(col_state_q + 2'd1);
    // Column 3 is classified from the live synchronized rows on its sample cycle.
    assign snap_full   = {sync2_q, snap_q};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (!snap_full[i]) begin
                low_cnt = low_cnt + 5'd1;
                low_idx = 4'(i);
            end
        end
        scan_res.code = 4'h0;
        if (low_cnt == 5'd0) begin
            scan_res.cls = RES_NONE;
        end else if (low_cnt == 5'd1) begin
            scan_res.cls  = RES_SINGLE;
            scan_res.code = KEY_MAP[{low_idx, 2'b00} +: 4];
        end else begin
            scan_res.cls = RES_MULTI;
        end
    end

    assign same_res = (scan_res == prev_q);
    // Only the scan that first lifts the count to the threshold accepts.
    assign accept   = scan_done && same_res && (stable_q == STABLE_MAX - SW'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            col_state_q <= COL0;
            col_q       <= 4'b1110;
            dwell_q     <= '0;
            snap_q      <= '1;
            prev_q      <= '{cls: RES_NONE, code: 4'h0};
            stable_q    <= '0;
        end else begin
            sync1_q <= kp.row;
            sync2_q <= sync1_q;
            if (sample) begin
                dwell_q     <= '0;
                col_state_q <= col_state_d;
                col_q       <= ~(4'b0001 << col_state_d);
                if (col_state_q != COL3) begin
                    snap_q[{col_state_q, 2'b00} +: 4] <= sync2_q;
                end
                if (scan_done) begin
                    if (!same_res) begin
                        stable_q <= SW'(1);
                        prev_q   <= scan_res;
                    end else if (stable_q != STABLE_MAX) begin
                        stable_q <= stable_q + SW'(1);
                    end
                end
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_state_q <= IDLE;
            key_val_q   <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            case (key_state_q)
                IDLE: begin
                    if (accept && scan_res.cls == RES_SINGLE) begin
                        key_val_q   <= scan_res.code;
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        key_state_q <= PRESSED;
                    end
                end
                PRESSED: begin
                    // A different stable key is ignored until a stable release.
                    if (accept && scan_res.cls == RES_NONE) begin
                        key_held_q  <= 1'b0;
                        key_state_q <= IDLE;
                    end
                end
                default: key_state_q <= IDLE;
            endcase
        end
    end

    assign kp.col       = col_q;
    assign kp.key_val   = key_val_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder: a keypad model drives rows from col and the
// pressed-key set; a negedge monitor matches every valid pulse against queued expectations.
module tb_keypad_decoder;
    localparam int SC = 8;
    localparam int DS = 3;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;   // bit r*4+c set means key (row r, col c) is pressed
    int          cyc;
    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    keypad_decoder_if kp_if ();

    keypad_decoder #(
        .SCAN_CYCLES   (SC),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kp_if)
    );

    function automatic logic [3:0] rows_for(input logic [15:0] k, input logic [3:0] c);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ~|(k[i*4 +: 4] & ~c);
        return r;
    endfunction

    function automatic logic [15:0] key_bit(input int r, input int c);
        return 16'd1 << (r * 4 + c);
    endfunction

    assign kp_if.row = rows_for(keys, kp_if.col);

    // cyc equals the number of rising edges seen since reset released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("col_one_low", 32'($countones(~kp_if.col)), 32'd1);
            if (kp_if.key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: key_val %0h at cycle %0d, no pulse expected",
                             kp_if.key_val, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    check("pulse_val", 32'(kp_if.key_val), 32'(e.val));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete, reached cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_col;
        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(kp_if.col), 32'hE);
        check("rst_val", 32'(kp_if.key_val), 32'h0);
        check("rst_valid", 32'(kp_if.key_valid), 32'h0);
        check("rst_held", 32'(kp_if.key_held), 32'h0);

        // Idle: columns rotate every SC cycles, outputs stay quiet.
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            wait_to(8 * k + 4);
            exp_col = ~(4'b0001 << ((cyc / SC) % 4));
            check("idle_col", 32'(kp_if.col), 32'(exp_col));
            check("idle_outs", {27'd0, kp_if.key_held, kp_if.key_val}, 32'd0);
        end

        // Key 5 held through reset release.
        rst_n = 1'b0;
        keys  = key_bit(1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        push(4'h5, 96);
        wait_to(95);  check("k5_held_before", 32'(kp_if.key_held), 32'd0);
        wait_to(96);  check("k5_held", 32'(kp_if.key_held), 32'd1);
                      check("k5_val", 32'(kp_if.key_val), 32'h5);
        wait_to(160); check("k5_still_held", 32'(kp_if.key_held), 32'd1);

        // Release 5, then press D.
        keys = '0;
        wait_to(255); check("rel5_held_before", 32'(kp_if.key_held), 32'd1);
        wait_to(256); check("rel5_held", 32'(kp_if.key_held), 32'd0);
                      check("rel5_val_kept", 32'(kp_if.key_val), 32'h5);
        keys = key_bit(3, 3);
        push(4'hD, 352);
        wait_to(352); check("kD_held", 32'(kp_if.key_held), 32'd1);
                      check("kD_val", 32'(kp_if.key_val), 32'hD);
        keys = '0;
        wait_to(448); check("relD_held", 32'(kp_if.key_held), 32'd0);

        // Key 8 bounces on alternate scans, then holds.
        keys = key_bit(2, 1);
        wait_to(480); keys = '0;
        wait_to(512); keys = key_bit(2, 1);
        wait_to(544); keys = '0;
        wait_to(576); keys = key_bit(2, 1);
        push(4'h8, 672);
        wait_to(671); check("k8_held_before", 32'(kp_if.key_held), 32'd0);
        wait_to(672); check("k8_val", 32'(kp_if.key_val), 32'h8);
                      check("k8_held", 32'(kp_if.key_held), 32'd1);
        keys = '0;
        wait_to(768); check("rel8_held", 32'(kp_if.key_held), 32'd0);

        // Keys 1 and A together for 10 scans, then A dropped.
        keys = key_bit(0, 0) | key_bit(0, 3);
        wait_to(1088); check("multi_held", 32'(kp_if.key_held), 32'd0);
                       check("multi_val", 32'(kp_if.key_val), 32'h8);
        keys = key_bit(0, 0);
        push(4'h1, 1184);
        wait_to(1184); check("k1_val", 32'(kp_if.key_val), 32'h1);
                       check("k1_held", 32'(kp_if.key_held), 32'd1);
        keys = '0;
        wait_to(1280); check("rel1_held", 32'(kp_if.key_held), 32'd0);

        // Key 7: reset lands on the pulse cycle, then re-acceptance.
        keys = key_bit(2, 0);
        push(4'h7, 1376);
        wait_to(1376);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(kp_if.key_valid), 32'd0);
        check("midrst_held", 32'(kp_if.key_held), 32'd0);
        check("midrst_val", 32'(kp_if.key_val), 32'h0);
        check("midrst_col", 32'(kp_if.col), 32'hE);
        repeat (3) @(negedge clk);
        push(4'h7, 96);
        rst_n = 1'b1;
        wait_to(95);  check("k7_held_before", 32'(kp_if.key_held), 32'd0);
        wait_to(96);  check("k7_held", 32'(kp_if.key_held), 32'd1);
                      check("k7_val", 32'(kp_if.key_val), 32'h7);
        wait_to(160);
        keys = '0;
        repeat (4) @(negedge clk);
        check("pulses_outstanding", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
